// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus responder: line width helper, FSM state
// encoding and the captured command record.
package mem_bus_pkg;

  function automatic int line_w(input int data_width, input int offset_length);
    return data_width * (1 << offset_length);
  endfunction

  // The command record is sized for the default geometry; the responder's
  // ADDR_WIDTH and line width must not exceed these.
  localparam int CMD_ADDR_W = 64;
  localparam int CMD_LINE_W = line_w(64, 5);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  store;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LINE_W-1:0] line;
  } cmd_t;

endpackage

// File: rtl/mem_line_ram.sv
// Line-wide backing store: synchronous write, combinational read on a single
// shared address.
module mem_line_ram #(
  parameter int LINES_LOG2 = 8,
  parameter int WIDTH      = 2048
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LINES_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**LINES_LOG2];

  // NOTE: the array has no reset; contents must survive reset_n, and a reset
  // loop over every entry would also prevent mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Fixed-latency line-load/store responder for a cache bus.
// Optional feature macro: MEM_BUS_RESP_ERR_EN adds bus_error and out-of-range checking.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int OFFSET_LENGTH  = 5,
  parameter int MEM_LINES_LOG2 = 8,
  parameter int LATENCY        = 4,
  localparam int LINE_W        = line_w(DATA_WIDTH, OFFSET_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  command_valid,
  input  logic                  command_store,
  input  logic [ADDR_WIDTH-1:0] command_addr,
  input  logic [LINE_W-1:0]     data_to_bus,
  input  logic                  command_rready,
  output logic                  bus_ready,
  output logic                  bus_valid,
  output logic [LINE_W-1:0]     data_from_bus
`ifdef MEM_BUS_RESP_ERR_EN
  ,
  output logic                  bus_error
`endif
);

  localparam int         IDX_HI   = OFFSET_LENGTH + MEM_LINES_LOG2;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  cmd_t                      cmd_q, cmd_d;
  logic [LINE_W-1:0]         rdata_d;
  logic [LINE_W-1:0]         mem_rdata;
  logic                      mem_we;
  logic                      addr_err;
  logic [MEM_LINES_LOG2-1:0] line_idx;

  assign line_idx = cmd_q.addr[IDX_HI-1:OFFSET_LENGTH];

`ifdef MEM_BUS_RESP_ERR_EN
  logic unused_offset_bits;
  assign addr_err           = |cmd_q.addr[ADDR_WIDTH-1:IDX_HI];
  assign bus_error          = (state_q == RESP) && addr_err;
  assign unused_offset_bits = ^cmd_q.addr[OFFSET_LENGTH-1:0];
`else
  // Upper address bits alias onto the backing store.
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{cmd_q.addr[ADDR_WIDTH-1:IDX_HI], cmd_q.addr[OFFSET_LENGTH-1:0]};
`endif

  // Ready is gated by reset_n so it stays low for the whole reset pulse.
  assign bus_ready = (state_q == IDLE) && reset_n;
  assign bus_valid = (state_q == RESP);

  // NOTE: every state element uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      data_from_bus <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      data_from_bus <= rdata_d;
    end
  end

  // NOTE: defaults first so no path leaves an output unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = data_from_bus;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (command_valid && bus_ready) begin
          cmd_d.store = command_store;
          cmd_d.addr  = CMD_ADDR_W'(command_addr);
          cmd_d.line  = CMD_LINE_W'(data_to_bus);
          cnt_d       = CNT_INIT;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          if (cmd_q.store) mem_we  = !addr_err;
          else             rdata_d = addr_err ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (command_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mem_line_ram #(
    .LINES_LOG2(MEM_LINES_LOG2),
    .WIDTH     (LINE_W)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we),
    .addr (line_idx),
    .wdata(cmd_q.line[LINE_W-1:0]),
    .rdata(mem_rdata)
  );

endmodule
